// File: rtl/data_out_port.sv
// Egress byte port: small FIFO fed by the router, drained onto the external
// bus one byte at a time with a four-phase data_on_bus / bus_ack handshake.
module data_out_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic              fwd_valid,
  output logic              fwd_ready,
  output logic [DATA_W-1:0] bus_data,
  output logic              data_on_bus,
  input  logic              bus_ack,
  output logic [ADDR_W:0]   count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic                data_on_bus_q, data_on_bus_d;
  logic                push;
  logic                pop;

  // Ready comes from the registered count, so a push never lands on a full FIFO.
  assign fwd_ready   = (count_q != (ADDR_W+1)'(DEPTH));
  assign push        = fwd_valid && fwd_ready;
  assign bus_data    = bus_data_q;
  assign data_on_bus = data_on_bus_q;
  assign count       = count_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    bus_data_d    = bus_data_q;
    data_on_bus_d = data_on_bus_q;
    pop           = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A bus_ack still high from a previous transfer holds off the request.
        if ((count_q != '0) && !bus_ack) begin
          state_d       = DRIVE;
          bus_data_d    = mem_q[rd_ptr_q];
          data_on_bus_d = 1'b1;
          pop           = 1'b1;
        end
      end
      DRIVE: begin
        if (bus_ack) begin
          state_d       = RELEASE;
          data_on_bus_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!bus_ack) begin
          if (count_q != '0) begin
            state_d       = DRIVE;
            bus_data_d    = mem_q[rd_ptr_q];
            data_on_bus_d = 1'b1;
            pop           = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d       = IDLE;
        data_on_bus_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      bus_data_q    <= '0;
      data_on_bus_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      bus_data_q    <= bus_data_d;
      data_on_bus_q <= data_on_bus_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fwd_data;
    end
  end

endmodule

// File: tb/tb_data_out_port.sv
// Directed self-checking bench for data_out_port: reset, single byte, fill,
// ordering with pointer wrap, simultaneous push/pop and stale acknowledge.
module tb_data_out_port;

  logic       clk;
  logic       reset;
  logic [7:0] fwd_data;
  logic       fwd_valid;
  logic       fwd_ready;
  logic [7:0] bus_data;
  logic       data_on_bus;
  logic       bus_ack;
  logic [2:0] count;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  data_out_port #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .fwd_data    (fwd_data),
    .fwd_valid   (fwd_valid),
    .fwd_ready   (fwd_ready),
    .bus_data    (bus_data),
    .data_on_bus (data_on_bus),
    .bus_ack     (bus_ack),
    .count       (count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full four-phase transfer; returns the byte seen and whether it completed.
  task automatic handshake(input int delay, output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    while (!data_on_bus && n < 60) begin
      tick();
      n++;
    end
    if (!data_on_bus) begin
      ok = 1'b0;
      b  = 8'h00;
      return;
    end
    b = bus_data;
    for (int i = 0; i < delay; i++) tick();
    bus_ack = 1'b1;
    n = 0;
    while (data_on_bus && n < 60) begin
      tick();
      n++;
    end
    if (data_on_bus) ok = 1'b0;
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    tests_run++;
    if (data_on_bus !== 1'b0 || count !== 3'd0 || busy !== 1'b0 ||
        fwd_ready !== 1'b1 || bus_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: dob=%b count=%0d busy=%b ready=%b data=%h, want 0 0 0 1 00",
               data_on_bus, count, busy, fwd_ready, bus_data);
    end
    fwd_data  = 8'h77;
    fwd_valid = 1'b1;
    tick();
    fwd_valid = 1'b0;
    fwd_data  = 8'h78;
    fwd_valid = 1'b1;
    tick();
    fwd_valid = 1'b0;
    n = 0;
    while (!data_on_bus && n < 10) begin
      tick();
      n++;
    end
    tests_run++;
    if (data_on_bus !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_setup_drive: dob=%b busy=%b, want 1 1", data_on_bus, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (data_on_bus !== 1'b0 || count !== 3'd0 || busy !== 1'b0 ||
        fwd_ready !== 1'b1 || bus_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_drive: dob=%b count=%0d busy=%b ready=%b data=%h, want 0 0 0 1 00",
               data_on_bus, count, busy, fwd_ready, bus_data);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0 || data_on_bus !== 1'b0 || count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_idle: busy=%b dob=%b count=%0d, want 0 0 0",
               busy, data_on_bus, count);
    end
  endtask

  task automatic test_single_byte();
    fwd_data  = 8'hA5;
    fwd_valid = 1'b1;
    tick();
    fwd_valid = 1'b0;
    tests_run++;
    if (count !== 3'd1 || data_on_bus !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_after_push: count=%0d dob=%b, want 1 0", count, data_on_bus);
    end
    tick();
    tests_run++;
    if (data_on_bus !== 1'b1 || bus_data !== 8'hA5 || count !== 3'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: dob=%b data=%h count=%0d busy=%b, want 1 a5 0 1",
               data_on_bus, bus_data, count, busy);
    end
    bus_ack = 1'b1;
    tick();
    tests_run++;
    if (data_on_bus !== 1'b0 || bus_data !== 8'hA5 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_release: dob=%b data=%h busy=%b, want 0 a5 1",
               data_on_bus, bus_data, busy);
    end
    bus_ack = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || count !== 3'd0 || data_on_bus !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: busy=%b count=%0d dob=%b, want 0 0 0",
               busy, count, data_on_bus);
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_count [6];
    logic [7:0] b;
    bit         ok;
    exp_count = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    for (int i = 0; i < 6; i++) begin
      fwd_data  = 8'(i + 1);
      fwd_valid = 1'b1;
      tick();
      tests_run++;
      if (count !== exp_count[i]) begin
        tests_failed++;
        $display("[TB] FAIL fill_count_%0d: count=%0d, want %0d", i, count, exp_count[i]);
      end
    end
    fwd_valid = 1'b0;
    tests_run++;
    if (fwd_ready !== 1'b0 || data_on_bus !== 1'b1 || bus_data !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL fill_full: ready=%b dob=%b data=%h, want 0 1 01",
               fwd_ready, data_on_bus, bus_data);
    end
    for (int i = 0; i < 5; i++) begin
      handshake(1, b, ok);
      tests_run++;
      if (!ok || b !== 8'(i + 1)) begin
        tests_failed++;
        $display("[TB] FAIL fill_drain_%0d: got %h ok=%b, want %h", i, b, ok, 8'(i + 1));
      end
    end
    tick();
    tick();
    tests_run++;
    if (count !== 3'd0 || busy !== 1'b0 || data_on_bus !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fill_no_overwrite: count=%0d busy=%b dob=%b, want 0 0 0 (06 dropped)",
               count, busy, data_on_bus);
    end
  endtask

  task automatic test_order_wrap();
    int         delays [12];
    logic [7:0] got [12];
    bit         oks [12];
    delays = '{0, 3, 1, 5, 2, 0, 4, 1, 0, 5, 2, 3};
    fork
      begin
        int idx;
        idx = 0;
        while (idx < 12) begin
          fwd_data  = 8'(8'h10 + idx);
          fwd_valid = 1'b1;
          if (fwd_ready) begin
            tick();
            idx++;
          end else begin
            tick();
          end
        end
        fwd_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          logic [7:0] b;
          bit         ok;
          handshake(delays[k], b, ok);
          got[k] = b;
          oks[k] = ok;
        end
      end
    join
    for (int k = 0; k < 12; k++) begin
      tests_run++;
      if (!oks[k] || got[k] !== 8'(8'h10 + k)) begin
        tests_failed++;
        $display("[TB] FAIL order_%0d: got %h ok=%b, want %h", k, got[k], oks[k], 8'(8'h10 + k));
      end
    end
    tick();
    tick();
    tests_run++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL order_end: count=%0d busy=%b, want 0 0", count, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    bit         ok;
    for (int i = 0; i < 3; i++) begin
      fwd_data  = 8'(8'h20 + i);
      fwd_valid = 1'b1;
      tick();
    end
    fwd_valid = 1'b0;
    tests_run++;
    if (count !== 3'd2 || data_on_bus !== 1'b1 || bus_data !== 8'h20) begin
      tests_failed++;
      $display("[TB] FAIL simul_setup: count=%0d dob=%b data=%h, want 2 1 20",
               count, data_on_bus, bus_data);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack   = 1'b0;
    fwd_data  = 8'h23;
    fwd_valid = 1'b1;
    tick();
    fwd_valid = 1'b0;
    tests_run++;
    if (count !== 3'd2 || data_on_bus !== 1'b1 || bus_data !== 8'h21) begin
      tests_failed++;
      $display("[TB] FAIL simul_push_pop: count=%0d dob=%b data=%h, want 2 1 21",
               count, data_on_bus, bus_data);
    end
    for (int i = 1; i < 4; i++) begin
      handshake(0, b, ok);
      tests_run++;
      if (!ok || b !== 8'(8'h20 + i)) begin
        tests_failed++;
        $display("[TB] FAIL simul_order_%0d: got %h ok=%b, want %h", i, b, ok, 8'(8'h20 + i));
      end
    end
    tick();
    tick();
    tests_run++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL simul_end: count=%0d busy=%b, want 0 0", count, busy);
    end
  endtask

  task automatic test_stale_ack();
    bus_ack   = 1'b1;
    fwd_data  = 8'h3C;
    fwd_valid = 1'b1;
    tick();
    fwd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (data_on_bus !== 1'b0 || count !== 3'd1 || busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stale_hold_%0d: dob=%b count=%0d busy=%b, want 0 1 0",
                 i, data_on_bus, count, busy);
      end
    end
    bus_ack = 1'b0;
    tick();
    tests_run++;
    if (data_on_bus !== 1'b1 || bus_data !== 8'h3C || count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL stale_request: dob=%b data=%h count=%0d, want 1 3c 0",
               data_on_bus, bus_data, count);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || data_on_bus !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stale_done: busy=%b dob=%b, want 0 0", busy, data_on_bus);
    end
  endtask

  initial begin
    reset     = 1'b1;
    fwd_data  = 8'h00;
    fwd_valid = 1'b0;
    bus_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single_byte();
    test_fill();
    test_order_wrap();
    test_back_to_back();
    test_stale_ack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
